fifo_wr_ctrl: RTL and testbench

Write-side flow controller for the clock-domain-crossing FIFO used between CGRA tiles. It lives entirely in the `clk_wr` domain and accepts words from an upstream valid/ready producer. It drives the FIFO's `we`/`data_in` pair and never overruns the FIFO, because it keeps its own credit count. Credits come back from the `clk_rd` domain as a read toggle, which this block synchronises; it also supports an orderly flush-to-idle.

---
 rtl/fifo_wr_ctrl_if.sv | 20 ++
 rtl/fifo_wr_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_wr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// Upstream valid/ready handshake into the CDC FIFO write controller.
interface fifo_wr_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side flow controller for the CGRA clock-domain-crossing FIFO.
// Tracks free FIFO slots as credits, takes credit returns as a toggle from
// the read clock domain, and supports an orderly flush back to idle.
module fifo_wr_ctrl #(
  parameter int DEPTH_P2 = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 1 << DEPTH_P2
) (
  input  logic                clk_wr,
  input  logic                rst,
  input  logic                chip_en,
  fifo_wr_ctrl_if.slave       up,
  input  logic                rd_tog,
  input  logic                flush,
  output logic                we,
  output logic [WIDTH-1:0]    data_out,
  output logic [DEPTH_P2:0]   credits,
  output logic                idle,
  output logic                overflow_err
);

  localparam logic [DEPTH_P2:0] CRED_MAX = (DEPTH_P2 + 1)'(DEPTH);
  localparam logic [DEPTH_P2:0] CRED_ONE = (DEPTH_P2 + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready;
  logic              push;
  logic              ret;
  logic              s1;
  logic              s2;
  logic              s3;
  logic [DEPTH_P2:0] credits_nxt;
  logic              ovf_hit;

  // Saturating credit update; the top bit flags a return that arrived with
  // every slot already free (the count then holds at its maximum).
  function automatic logic [DEPTH_P2+1:0] credit_next(
    input logic [DEPTH_P2:0] cur,
    input logic              take,
    input logic              give
  );
    logic [DEPTH_P2+1:0] res;
    res = {1'b0, cur};
    if (take && !give) begin
      res = {1'b0, cur - CRED_ONE};
    end else if (give && !take) begin
      if (cur == CRED_MAX) begin
        res = {1'b1, cur};
      end else begin
        res = {1'b0, cur + CRED_ONE};
      end
    end
    return res;
  endfunction

  // Read-toggle synchroniser plus edge stage; runs regardless of chip_en.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rd_tog;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ret  = s2 ^ s3;
  assign push = up.in_valid & ready;
  assign {ovf_hit, credits_nxt} = credit_next(credits, push, ret);
  assign up.in_ready = ready;
  assign idle = (state == IDLE);

  // State register for the accept/flush FSM.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the combinational ready; chip_en low freezes the FSM.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (chip_en && !flush) state_nxt = RUN;
      end
      RUN: begin
        ready = chip_en && (credits != '0);
        if (chip_en && flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (chip_en && (credits == CRED_MAX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Credit count and sticky overflow flag.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      credits      <= CRED_MAX;
      overflow_err <= 1'b0;
    end else begin
      credits <= credits_nxt;
      if (ovf_hit) overflow_err <= 1'b1;
    end
  end

  // FIFO write strobe and data; data holds between pushes.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      we       <= 1'b0;
      data_out <= '0;
    end else begin
      we <= push;
      if (push) data_out <= up.in_data;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios followed by random traffic,
// all checked against a FIFO-occupancy reference model.
module tb_fifo_wr_ctrl;
  localparam int DEPTH_P2 = 2;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 1 << DEPTH_P2;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FLUSH  = 2;

  logic              clk_wr = 1'b0;
  logic              rst;
  logic              chip_en;
  logic              rd_tog;
  logic              flush;
  logic              we;
  logic [WIDTH-1:0]  data_out;
  logic [DEPTH_P2:0] credits;
  logic              idle;
  logic              overflow_err;

  fifo_wr_ctrl_if #(.WIDTH(WIDTH)) up ();

  fifo_wr_ctrl #(
    .DEPTH_P2(DEPTH_P2),
    .WIDTH   (WIDTH)
  ) dut (
    .clk_wr      (clk_wr),
    .rst         (rst),
    .chip_en     (chip_en),
    .up          (up),
    .rd_tog      (rd_tog),
    .flush       (flush),
    .we          (we),
    .data_out    (data_out),
    .credits     (credits),
    .idle        (idle),
    .overflow_err(overflow_err)
  );

  always #5 clk_wr = ~clk_wr;

  int total = 0;
  int bad   = 0;

  // Reference model: words sitting in the FIFO, scheduled credit arrivals.
  int         mq[$];
  int         pend[$];
  int         mode;
  int         cyc;
  int         last_tog;
  logic       m_we;
  logic [7:0] m_data;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_cred();
    return DEPTH - mq.size();
  endfunction

  function automatic logic m_ready();
    return chip_en && (mode == M_RUN) && (m_cred() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    mode   = M_IDLE;
    m_we   = 1'b0;
    m_data = '0;
    m_ovf  = 1'b0;
  endtask

  // A read-side pop: the return reaches the credit count two edges later.
  task automatic toggle();
    rd_tog   = ~rd_tog;
    pend.push_back(cyc + 2);
    last_tog = cyc;
  endtask

  task automatic model_edge();
    logic push;
    logic ret;
    int   cred_old;
    cred_old = m_cred();
    push     = up.in_valid && m_ready();
    ret      = (pend.size() > 0) && (pend[0] == cyc);
    if (ret) void'(pend.pop_front());
    m_we = push;
    if (push) begin
      m_data = up.in_data;
      mq.push_back(int'(up.in_data));
    end
    if (ret) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_ovf = 1'b1;
    end
    if (chip_en) begin
      if (mode == M_IDLE && !flush) mode = M_RUN;
      else if (mode == M_RUN && flush) mode = M_FLUSH;
      else if (mode == M_FLUSH && cred_old == DEPTH) mode = M_IDLE;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("in_ready", up.in_ready, m_ready());
    chk("we", we, m_we);
    chk("data_out", data_out, m_data);
    chk("credits", credits, m_cred());
    chk("idle", idle, mode == M_IDLE);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic tick();
    @(negedge clk_wr);
    check_all();
    @(posedge clk_wr);
    model_edge();
    #1;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    chip_en     = 1'b1;
    rd_tog      = 1'b0;
    flush       = 1'b0;
    up.in_valid = 1'b0;
    up.in_data  = '0;
    cyc         = 0;
    last_tog    = -10;
    model_reset();
    #1;
    chk("rst_we", we, 0);
    chk("rst_data", data_out, 0);
    chk("rst_credits", credits, DEPTH);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_ready", up.in_ready, 0);
    @(posedge clk_wr);
    @(posedge clk_wr);
    #1 rst = 1'b0;

    // Leave idle on the first edge.
    tick();
    chk("start_idle", idle, 0);
    chk("start_ready", up.in_ready, 1);
    chk("start_credits", credits, 4);

    // Fill the FIFO back to back; a fifth word must wait.
    for (int i = 1; i <= 4; i++) begin
      up.in_valid = 1'b1;
      up.in_data  = 8'(i * 8'h11);
      tick();
    end
    up.in_data = 8'h55;
    tick();
    chk("full_credits", credits, 0);
    chk("full_ready", up.in_ready, 0);
    chk("full_data", data_out, 8'h44);

    // One credit returns and the held word goes through.
    toggle();
    tick();
    tick();
    tick();
    tick();
    up.in_valid = 1'b0;
    chk("ret_we", we, 1);
    chk("ret_data", data_out, 8'h55);
    chk("ret_credits", credits, 0);

    // Two credits back, then a push coinciding with a return.
    toggle();
    tick();
    tick();
    toggle();
    for (int i = 0; i < 4; i++) tick();
    chk("two_credits", credits, 2);
    toggle();
    tick();
    tick();
    up.in_valid = 1'b1;
    up.in_data  = 8'h66;
    tick();
    up.in_valid = 1'b0;
    chk("coinc_credits", credits, 2);
    chk("coinc_we", we, 1);

    // Three outstanding, then flush and drain.
    up.in_valid = 1'b1;
    up.in_data  = 8'h77;
    tick();
    up.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    up.in_valid = 1'b1;
    up.in_data  = 8'h88;
    for (int k = 0; k < 3; k++) begin
      toggle();
      tick();
      tick();
      chk("flush_ready", up.in_ready, 0);
    end
    n = 0;
    while (credits != 4 && n < 10) begin
      tick();
      n++;
    end
    chk("flush_credits", credits, 4);
    tick();
    chk("flush_idle", idle, 1);
    tick();
    chk("flush_hold_idle", idle, 1);
    up.in_valid = 1'b0;
    flush = 1'b0;
    tick();
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      chip_en     = ($urandom_range(0, 9) != 0);
      up.in_valid = 1'($urandom_range(0, 1));
      up.in_data  = 8'($urandom);
      if ($urandom_range(0, 29) == 0) flush = ~flush;
      if (mq.size() > pend.size() && cyc - last_tog >= 2 && $urandom_range(0, 2) == 0) toggle();
      tick();
    end

    // Drain everything back to a full credit count.
    chip_en     = 1'b1;
    flush       = 1'b0;
    up.in_valid = 1'b0;
    n = 0;
    while ((mq.size() > 0 || pend.size() > 0) && n < 60) begin
      if (mq.size() > pend.size() && cyc - last_tog >= 2) toggle();
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    chk("drain_credits", credits, 4);

    // Return with nothing outstanding: sticky overflow.
    toggle();
    tick();
    tick();
    tick();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_credits", credits, 4);
    tick();
    tick();
    chk("ovf_sticky", overflow_err, 1);
    up.in_valid = 1'b1;
    up.in_data  = 8'hA5;
    tick();
    up.in_valid = 1'b0;
    chk("pre_rst_we", we, 1);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst    = 1'b1;
    rd_tog = 1'b0;
    #1;
    model_reset();
    chk("arst_ovf", overflow_err, 0);
    chk("arst_we", we, 0);
    chk("arst_credits", credits, 4);
    chk("arst_data", data_out, 0);
    chk("arst_idle", idle, 1);
    @(posedge clk_wr);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_ready", up.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
